// File: rtl/nmr_pkg.sv
// ============================================================================
//  Module      : nmr_pkg
//  Description : Shared constants for the NMR acquisition readout path:
//                FSM state codes, status-bit indices and default widths.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package nmr_pkg;

    // Default BRAM geometry
    localparam int NMR_ADDR_W = 16;
    localparam int NMR_DATA_W = 32;

    // Readout FSM state encoding
    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_LOAD   = 3'd1;
    localparam logic [2:0] ST_STREAM = 3'd2;
    localparam logic [2:0] ST_DRAIN  = 3'd3;
    localparam logic [2:0] ST_DONE   = 3'd4;

    // Bit positions inside the sts word
    localparam int STS_DONE  = 0;
    localparam int STS_BUSY  = 1;
    localparam int STS_CLAMP = 2;
    localparam int STS_ABORT = 3;

endpackage

`default_nettype wire

// File: rtl/nmr_skid_fifo.sv
// ============================================================================
//  Module      : nmr_skid_fifo
//  Description : Small synchronous first-word-fall-through FIFO sitting
//                between the BRAM read port and the AXI-Stream output.
//                flush empties it in one cycle and wins over push.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module nmr_skid_fifo
    import nmr_pkg::*;
#(
    parameter int WIDTH = NMR_DATA_W + 1,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign w_do_push = push && (r_count != CNT_W'(DEPTH));
    assign w_do_pop  = pop && (r_count != '0);
    assign empty     = (r_count == '0);
    assign count     = r_count;
    // Head word is forced to zero while empty so the stream bus idles at 0
    assign pop_data  = empty ? '0 : r_mem[r_rd_ptr];

    // Storage array; contents are don't-care until a push marks them valid
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    // Pointer and occupancy tracking, cleared by reset or flush
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/nmr_acq_reader.sv
// ============================================================================
//  Module      : nmr_acq_reader
//  Description : Reads captured NMR samples out of the acquisition BRAM and
//                streams them to the host DMA on an AXI-Stream master, with
//                frame-based TLAST, abort, count clamping and status.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module nmr_acq_reader
    import nmr_pkg::*;
#(
    parameter int ADDR_W     = NMR_ADDR_W,
    parameter int DATA_W     = NMR_DATA_W,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [31:0]       nb_of_sample,
    input  logic [15:0]       frame_len,
    output logic              ram_en,
    output logic [ADDR_W-1:0] ram_addr,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic [DATA_W-1:0] m_axis_tdata,
    output logic              m_axis_tvalid,
    output logic              m_axis_tlast,
    input  logic              m_axis_tready,
    output logic [31:0]       sent_count,
    output logic [31:0]       sts
);

    localparam int          CNT_W     = $clog2(FIFO_DEPTH) + 1;
    localparam logic [32:0] BUF_WORDS = 33'd1 << ADDR_W;

    logic [2:0]        r_state;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_count;
    logic [15:0]       r_frame_len;
    logic [31:0]       r_issued;
    logic [31:0]       r_push_idx;
    logic [15:0]       r_frame_cnt;
    logic              r_inflight;
    logic [31:0]       r_sent;
    logic              r_done;
    logic              r_busy;
    logic              r_clamp;
    logic              r_abort;

    logic [CNT_W-1:0]  w_fifo_count;
    logic              w_fifo_empty;
    logic [DATA_W:0]   w_head;
    logic              w_start_ok;
    logic              w_clamp;
    logic [31:0]       w_count_in;
    logic              w_room;
    logic              w_rd_issue;
    logic              w_frame_end;
    logic              w_push_last;
    logic              w_hs;
    logic              w_enter_done;

    // Abort has priority over start; start only counts from an idle state
    assign w_start_ok = start && !abort && (r_state == ST_IDLE || r_state == ST_DONE);

    // Requests larger than the buffer are clamped to one full buffer pass
    assign w_clamp    = ({1'b0, nb_of_sample} > BUF_WORDS);
    assign w_count_in = w_clamp ? BUF_WORDS[31:0] : nb_of_sample;

    // A read is only issued when its data is guaranteed a FIFO slot
    assign w_room     = (32'(w_fifo_count) + 32'(r_inflight)) < 32'(FIFO_DEPTH);
    assign w_rd_issue = (r_state == ST_STREAM) && (r_issued < r_count) && w_room;

    // TLAST is decided as the word enters the FIFO
    assign w_frame_end = (r_frame_len != 16'd0) && (r_frame_cnt == r_frame_len - 16'd1);
    assign w_push_last = (r_push_idx == r_count - 32'd1) || w_frame_end;

    assign w_hs = m_axis_tvalid && m_axis_tready;

    assign w_enter_done = !abort &&
                          (((r_state == ST_LOAD) && (r_count == 32'd0)) ||
                           ((r_state == ST_DRAIN) && (w_fifo_count == '0) && !r_inflight));

    assign ram_en        = w_rd_issue;
    assign ram_addr      = r_addr;
    assign m_axis_tvalid = !w_fifo_empty;
    assign m_axis_tdata  = w_head[DATA_W-1:0];
    assign m_axis_tlast  = w_head[DATA_W];
    assign sent_count    = r_sent;

    always_comb begin
        sts            = 32'd0;
        sts[STS_DONE]  = r_done;
        sts[STS_BUSY]  = r_busy;
        sts[STS_CLAMP] = r_clamp;
        sts[STS_ABORT] = r_abort;
    end

    nmr_skid_fifo #(
        .WIDTH (DATA_W + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (abort),
        .push      (r_inflight),
        .push_data ({w_push_last, ram_rdata}),
        .pop       (w_hs),
        .pop_data  (w_head),
        .empty     (w_fifo_empty),
        .count     (w_fifo_count)
    );

    // Readout sequencing: load, stream reads, drain the FIFO, finish
    always_ff @(posedge clk) begin
        if (rst || abort) begin
            r_state <= ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (start) r_state <= ST_LOAD;
                end
                ST_LOAD: begin
                    r_state <= (r_count == 32'd0) ? ST_DONE : ST_STREAM;
                end
                ST_STREAM: begin
                    if (w_rd_issue && (r_issued == r_count - 32'd1)) r_state <= ST_DRAIN;
                end
                ST_DRAIN: begin
                    if (w_enter_done) r_state <= ST_DONE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Run parameters, read address and word counters
    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr      <= '0;
            r_count     <= '0;
            r_frame_len <= '0;
            r_issued    <= '0;
            r_push_idx  <= '0;
            r_frame_cnt <= '0;
        end else if (w_start_ok) begin
            r_addr      <= base_addr;
            r_count     <= w_count_in;
            r_frame_len <= frame_len;
            r_issued    <= '0;
            r_push_idx  <= '0;
            r_frame_cnt <= '0;
        end else begin
            if (w_rd_issue) begin
                r_addr   <= r_addr + 1'b1;
                r_issued <= r_issued + 32'd1;
            end
            if (r_inflight) begin
                r_push_idx  <= r_push_idx + 32'd1;
                r_frame_cnt <= w_frame_end ? 16'd0 : r_frame_cnt + 16'd1;
            end
        end
    end

    // One BRAM word is in flight the cycle after a read; abort discards it
    always_ff @(posedge clk) begin
        if (rst || abort) begin
            r_inflight <= 1'b0;
        end else begin
            r_inflight <= w_rd_issue;
        end
    end

    // Downstream handshake counter, survives abort, cleared on a new run
    always_ff @(posedge clk) begin
        if (rst || w_start_ok) begin
            r_sent <= '0;
        end else if (w_hs) begin
            r_sent <= r_sent + 32'd1;
        end
    end

    // Status flags: done is sticky until the next accepted start
    always_ff @(posedge clk) begin
        if (rst) begin
            r_done  <= 1'b0;
            r_busy  <= 1'b0;
            r_clamp <= 1'b0;
            r_abort <= 1'b0;
        end else if (abort) begin
            r_busy  <= 1'b0;
            r_abort <= 1'b1;
        end else if (w_start_ok) begin
            r_done  <= 1'b0;
            r_busy  <= 1'b1;
            r_clamp <= w_clamp;
            r_abort <= 1'b0;
        end else if (w_enter_done) begin
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
        end
    end

endmodule

`default_nettype wire
